// File: rtl/ram_arbiter_if.sv
// Bundle carrying both masters' request/access signals and the shared RAM port.
// The arbiter uses the slave view. A master-side model or bench uses the master view.
interface ram_arbiter_if #(
    parameter int AW = 10
);
    logic          req0;
    logic          req1;
    logic          gnt0;
    logic          gnt1;
    logic          yield0;
    logic          yield1;
    logic          clke0;
    logic          clke1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          clear_status;
    logic          err;
    logic          ram_clke;
    logic          ram_we;
    logic [AW-1:0] ram_addr;

    modport master (
        output req0, req1, clke0, clke1, we0, we1, addr0, addr1, clear_status,
        input  gnt0, gnt1, yield0, yield1, err, ram_clke, ram_we, ram_addr
    );

    modport slave (
        input  req0, req1, clke0, clke1, we0, we1, addr0, addr1, clear_status,
        output gnt0, gnt1, yield0, yield1, err, ram_clke, ram_we, ram_addr
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin owner arbiter for one single-port RAM shared by two masters.
// Ownership is per burst, with an idle turnaround between owners, a hold-time yield hint and a sticky violation flag.
module ram_arbiter #(
    parameter int RAM_SIZE = 1024,
    parameter int MAX_HOLD = 64
) (
    input logic         clk_i,
    input logic         rstn_i,
    ram_arbiter_if.slave bus
);
    // MAX_HOLD = 0 still needs a one-bit counter so the logic stays legal.
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          last_q;
    logic          last_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err_q;
    logic          err_d;
    logic          viol;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // On a tie, last_q = 1 means master 0 gets the grant.
                if (bus.req0 && (!bus.req1 || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.req1 && cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.req0 && cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new violation in the same cycle as a clear leaves the flag set.
    assign viol  = (bus.clke0 && state_q != OWN0) || (bus.clke1 && state_q != OWN1);
    assign err_d = viol || (err_q && !bus.clear_status);

    assign bus.gnt0   = (state_q == OWN0);
    assign bus.gnt1   = (state_q == OWN1);
    assign bus.yield0 = (state_q == OWN0) && (MAX_HOLD != 0) && (cnt_q == HOLD_MAX);
    assign bus.yield1 = (state_q == OWN1) && (MAX_HOLD != 0) && (cnt_q == HOLD_MAX);
    assign bus.err    = err_q;

    assign bus.ram_clke = (bus.gnt0 && bus.req0 && bus.clke0) || (bus.gnt1 && bus.req1 && bus.clke1);
    assign bus.ram_we   = (bus.gnt0 && bus.req0 && bus.we0) || (bus.gnt1 && bus.req1 && bus.we1);
    assign bus.ram_addr = bus.gnt0 ? bus.addr0 : (bus.gnt1 ? bus.addr1 : '0);
endmodule
